// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters over valid/ready handshakes.
// Optional macro ALU_ARB_FIXED_PRIO_EN: req0 always wins simultaneous requests.
module alu_req_arbiter #(
    parameter int WIDTH   = 8,
    parameter int OPW     = 6,
    parameter int ALU_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [OPW-1:0]   alu_op,
    output logic [2:0]       alu_in_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    localparam logic [2:0] SEL_CLR  = 3'b001;
    localparam logic [2:0] SEL_LOAD = 3'b010;
    localparam logic [2:0] SEL_HOLD = 3'b100;

    state_t     state_q;
    logic       grant_q;
    logic [3:0] lat_cnt;
    logic       gnt;
    logic       resp_done;

    assign resp_done = (state_q == RESP) && rsp_ready[grant_q];

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb gnt = ~req_valid[0];
`else
    logic rr_ptr;

    // A lone request wins outright; rr_ptr only breaks ties.
    always_comb gnt = (req_valid == 2'b11) ? rr_ptr : req_valid[1];

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= 1'b0;
        else if (resp_done)
            rr_ptr <= ~grant_q;
    end
`endif

    // NOTE: every output assigned here gets a default first, so no latch is inferred.
    always_comb begin
        req_ready = 2'b00;
        if (!rst && state_q == IDLE && |req_valid)
            req_ready[gnt] = 1'b1;
    end

    always_comb begin
        alu_in_sel = SEL_HOLD;
        if (rst)
            alu_in_sel = SEL_CLR;
        else if (state_q == ISSUE)
            alu_in_sel = SEL_LOAD;
    end

    assign rsp_valid = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (state_q != IDLE);
    assign state     = state_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            lat_cnt  <= 4'd0;
            alu_num1 <= '0;
            alu_num2 <= '0;
            alu_op   <= '0;
            rsp_data <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        grant_q  <= gnt;
                        alu_num1 <= gnt ? req1_a  : req0_a;
                        alu_num2 <= gnt ? req1_b  : req0_b;
                        alu_op   <= gnt ? req1_op : req0_op;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= 4'(ALU_LAT - 1);
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        rsp_data <= alu_out;
                        state_q  <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_done)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: transaction-level model checked every cycle
// plus directed scenarios with hand-computed values.
module tb_alu_req_arbiter;

    localparam int LAT    = 2;
    localparam int P_RESP = 2 + LAT;
    localparam logic [5:0] OP_ADD = 6'b000001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_ready;
    logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [5:0] req0_op = '0, req1_op = '0;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready = 2'b00;
    logic [7:0] rsp_data, alu_num1, alu_num2, alu_out;
    logic [5:0] alu_op;
    logic [2:0] alu_in_sel;
    logic       busy;
    logic [1:0] state;

    int n_vec = 0;
    int n_err = 0;

    alu_req_arbiter #(.WIDTH(8), .OPW(6), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_op(alu_op),
        .alu_in_sel(alu_in_sel), .alu_out(alu_out),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        return (op == OP_ADD) ? a + b : a ^ b;
    endfunction

    // Bench ALU: result valid LAT cycles after the LOAD edge.
    logic [7:0] alu_r1 = '0, alu_r2 = '0;
    always @(posedge clk) begin
        case (alu_in_sel)
            3'b001: begin alu_r1 <= '0; alu_r2 <= '0; end
            3'b010: begin alu_r1 <= alu_fn(alu_op, alu_num1, alu_num2); alu_r2 <= alu_r1; end
            default: alu_r2 <= alu_r1;
        endcase
    end
    assign alu_out = alu_r2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: phase = cycles since the accept edge (0 = idle).
    int         m_phase = 0;
    bit         m_owner = 1'b0;
    bit         m_rr = 1'b0;
    bit         model_on = 1'b0;
    logic [7:0] m_a = '0, m_b = '0, m_data = '0;
    logic [5:0] m_op = '0;

    function automatic bit model_grant(input logic [1:0] v, input bit rr);
`ifdef ALU_ARB_FIXED_PRIO_EN
        return !v[0];
`else
        if (v == 2'b11) return rr;
        return v[1];
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_on <= 1'b1;
            m_phase  <= 0;
            m_owner  <= 1'b0;
            m_rr     <= 1'b0;
            m_a      <= '0;
            m_b      <= '0;
            m_op     <= '0;
            m_data   <= '0;
        end else if (m_phase == 0) begin
            if (req_valid != 2'b00) begin
                m_owner <= model_grant(req_valid, m_rr);
                m_a     <= model_grant(req_valid, m_rr) ? req1_a  : req0_a;
                m_b     <= model_grant(req_valid, m_rr) ? req1_b  : req0_b;
                m_op    <= model_grant(req_valid, m_rr) ? req1_op : req0_op;
                m_phase <= 1;
            end
        end else if (m_phase < P_RESP) begin
            m_phase <= m_phase + 1;
            if (m_phase == P_RESP - 1) m_data <= alu_fn(m_op, m_a, m_b);
        end else if (rsp_ready[m_owner]) begin
            m_phase <= 0;
            m_rr    <= !m_owner;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            logic [1:0] e_ready, e_rv, e_state;
            logic [2:0] e_sel;
            e_ready = 2'b00;
            if (!rst && m_phase == 0 && req_valid != 2'b00)
                e_ready = model_grant(req_valid, m_rr) ? 2'b10 : 2'b01;
            e_rv    = (m_phase >= P_RESP) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
            e_state = (m_phase == 0) ? 2'b00 : (m_phase == 1) ? 2'b01 :
                      (m_phase < P_RESP) ? 2'b10 : 2'b11;
            e_sel   = rst ? 3'b001 : (m_phase == 1) ? 3'b010 : 3'b100;
            check("req_ready",  32'(req_ready),  32'(e_ready));
            check("rsp_valid",  32'(rsp_valid),  32'(e_rv));
            check("rsp_data",   32'(rsp_data),   32'(m_data));
            check("state",      32'(state),      32'(e_state));
            check("busy",       32'(busy),       32'(m_phase != 0));
            check("alu_in_sel", 32'(alu_in_sel), 32'(e_sel));
            check("alu_num1",   32'(alu_num1),   32'(m_a));
            check("alu_num2",   32'(alu_num2),   32'(m_b));
            check("alu_op",     32'(alu_op),     32'(m_op));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int w = 0;
        @(negedge clk);
        while (busy && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("idle_timeout", 32'(w < 50), 32'd1);
    endtask

    logic [1:0] grants [4];
    logic [1:0] exp_g  [4];

    initial begin
        // Reset sequence
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_sel", 32'(alu_in_sel), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        tick(); rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_sel", 32'(alu_in_sel), 32'h4);
        check("post_rst_state", 32'(state), 32'h0);

        // Single request 0x57 + 0x1A
        tick(); req_valid = 2'b01; req0_a = 8'h57; req0_b = 8'h1A; req0_op = OP_ADD;
        @(negedge clk); check("single_ready", 32'(req_ready), 32'h1);
        tick(); req_valid = 2'b00;
        @(negedge clk); check("single_load", 32'(alu_in_sel), 32'h2);
        tick(); tick(); tick();
        @(negedge clk);
        check("single_rsp_valid", 32'(rsp_valid), 32'h1);
        check("single_rsp_data", 32'(rsp_data), 32'h71);

        // Backpressure; rsp_ready on the other bit is ignored
        for (int i = 0; i < 10; i++) begin
            tick(); rsp_ready = 2'b10;
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp_rsp_data", 32'(rsp_data), 32'h71);
            check("bp_busy", 32'(busy), 32'h1);
        end
        tick(); rsp_ready = 2'b01;
        tick(); rsp_ready = 2'b00;
        @(negedge clk); check("bp_release_state", 32'(state), 32'h0);

        // Contention from a fresh reset
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        req_valid = 2'b11; rsp_ready = 2'b11;
        req0_a = 8'h01; req0_b = 8'h01; req1_a = 8'h02; req1_b = 8'h03; req1_op = OP_ADD;
        for (int k = 0; k < 4; k++) begin
            int w = 0;
            @(negedge clk);
            while (req_ready == 2'b00 && w < 20) begin
                @(negedge clk);
                w++;
            end
            check("grant_timeout", 32'(w < 20), 32'd1);
            grants[k] = req_ready;
        end
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        for (int k = 0; k < 4; k++) check($sformatf("grant_%0d", k), 32'(grants[k]), 32'(exp_g[k]));
        tick(); req_valid = 2'b00;
        wait_idle();
        tick(); rsp_ready = 2'b00;

        // Reset while in WAIT
        tick(); req_valid = 2'b01; req0_a = 8'h10; req0_b = 8'h20;
        tick(); req_valid = 2'b00;
        tick(); rst = 1'b1;
        @(negedge clk); check("midrst_in_sel", 32'(alu_in_sel), 32'h1);
        tick(); rst = 1'b0;
        @(negedge clk);
        check("midrst_state", 32'(state), 32'h0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        repeat (4) tick();
        req_valid = 2'b10; req1_a = 8'h33; req1_b = 8'h44;
        @(negedge clk); check("midrst_new_ready", 32'(req_ready), 32'h2);
        tick(); req_valid = 2'b00;
        begin
            int w = 0;
            @(negedge clk);
            while (rsp_valid == 2'b00 && w < 20) begin
                @(negedge clk);
                w++;
            end
            check("midrst_rsp_timeout", 32'(w < 20), 32'd1);
        end
        check("midrst_new_data", 32'(rsp_data), 32'h77);
        check("midrst_new_valid", 32'(rsp_valid), 32'h2);
        tick(); rsp_ready = 2'b10;
        tick(); rsp_ready = 2'b00;

        // Withdrawn req1 while busy serving req0
        req_valid = 2'b01; req0_a = 8'h05; req0_b = 8'h06;
        @(negedge clk); check("wd_ready0", 32'(req_ready), 32'h1);
        tick(); req_valid = 2'b10;
        tick();
        tick(); req_valid = 2'b00;
        tick(); rsp_ready = 2'b01;
        @(negedge clk); check("wd_rsp_data", 32'(rsp_data), 32'h0B);
        tick(); rsp_ready = 2'b00; req_valid = 2'b11;
        @(negedge clk);
`ifdef ALU_ARB_FIXED_PRIO_EN
        check("wd_next_grant", 32'(req_ready), 32'h1);
`else
        check("wd_next_grant", 32'(req_ready), 32'h2);
`endif
        tick(); req_valid = 2'b00; rsp_ready = 2'b11;
        wait_idle();
        tick(); rsp_ready = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
